// File: rtl/bomb_pkg.sv
// -----------------------------------------------------------------------------
// bomb_pkg
// Shared definitions for the bomb subsystem: grid geometry, cell-state
// encoding, player identifiers and small helpers for cell addressing.
//   GRID_W / MAP_W     : 10x10 grid, flattened to 100-bit bit planes
//   CELL_MIN/CELL_MAX  : interior coordinate range (border cells never used)
//   cell_index(x,y)    : flattened cell index 10*x+y
//   INTERIOR_MASK      : 1 for every interior cell, 0 on the border
// -----------------------------------------------------------------------------
package bomb_pkg;

    localparam int GRID_W   = 10;
    localparam int CELL_MIN = 1;
    localparam int CELL_MAX = 8;
    localparam int MAP_W    = GRID_W * GRID_W;

    // Cell state is {plane1, plane0}.
    typedef enum logic [1:0] {
        BOMB_EMPTY   = 2'd0,
        BOMB_FUSE1   = 2'd1,
        BOMB_FUSE2   = 2'd2,
        BOMB_EXPLODE = 2'd3
    } cellState_t;

    localparam logic PLAYER_A = 1'b0;
    localparam logic PLAYER_B = 1'b1;

    // 8 bits cover the whole 4-bit coordinate space (max 165), so callers
    // may compute an index before knowing the coordinate is in range.
    function automatic logic [7:0] cell_index(input logic [3:0] x, input logic [3:0] y);
        return 8'(x) * 8'd10 + 8'(y);
    endfunction

    function automatic logic inInterior(input logic [3:0] v);
        return (v >= 4'(CELL_MIN)) && (v <= 4'(CELL_MAX));
    endfunction

    function automatic logic [MAP_W-1:0] interiorMask();
        logic [MAP_W-1:0] m;
        m = '0;
        for (int x = CELL_MIN; x <= CELL_MAX; x++) begin
            for (int y = CELL_MIN; y <= CELL_MAX; y++) begin
                m[x*GRID_W + y] = 1'b1;
            end
        end
        return m;
    endfunction

    localparam logic [MAP_W-1:0] INTERIOR_MASK = interiorMask();

endpackage

// File: rtl/clk_edge_sync.sv
// -----------------------------------------------------------------------------
// clk_edge_sync
// Brings a slow, asynchronous clock-like signal into the clk domain as data
// and flags its rising edge.
//   clk       : sampling clock
//   rst       : asynchronous active-high reset
//   asyncIn   : raw slow signal
//   syncOut   : asyncIn after STAGES flops
//   risePulse : one clk cycle high when syncOut goes 0->1; the first clk edge
//               that can act on it is STAGES+1 edges after the raw edge
// -----------------------------------------------------------------------------
module clk_edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic asyncIn,
    output logic syncOut,
    output logic risePulse
);

    logic [STAGES-1:0] syncChain;
    logic              syncPrev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            syncChain <= '0;
            syncPrev  <= 1'b0;
        end else begin
            syncChain <= {syncChain[STAGES-2:0], asyncIn};
            syncPrev  <= syncChain[STAGES-1];
        end
    end

    assign syncOut   = syncChain[STAGES-1];
    assign risePulse = syncOut & ~syncPrev;

endmodule

// File: rtl/bomb_placer.sv
// -----------------------------------------------------------------------------
// bomb_placer
// Owns the registered bomb map fed to the bomb ticker. Places new bombs from
// player drop presses, re-absorbs the ticker's updated map once per bomb-clock
// tick and limits each player to MAX_BOMBS live bombs.
//   clk                   : system clock
//   rst                   : asynchronous active-high reset
//   bombClk               : slow bomb clock, sampled as data
//   game_state            : 0 = playing, otherwise game over
//   dropA/dropB           : debounced drop buttons (level)
//   playerAx/Ay, Bx/By    : player cell coordinates
//   i_updatedBombMap_0/1  : ticker output bit planes
//   o_curBombMap_0/1      : registered map driving the ticker
//   o_bombCountA/B        : live bombs per player
//   o_dropAckA/B          : one-cycle pulse, bomb placed
//   o_dropRejA/B          : one-cycle pulse, request refused
// -----------------------------------------------------------------------------
module bomb_placer
    import bomb_pkg::*;
#(
    parameter int MAX_BOMBS   = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bombClk,
    input  logic [1:0]       game_state,
    input  logic             dropA,
    input  logic             dropB,
    input  logic [3:0]       playerAx,
    input  logic [3:0]       playerAy,
    input  logic [3:0]       playerBx,
    input  logic [3:0]       playerBy,
    input  logic [MAP_W-1:0] i_updatedBombMap_0,
    input  logic [MAP_W-1:0] i_updatedBombMap_1,
    output logic [MAP_W-1:0] o_curBombMap_0,
    output logic [MAP_W-1:0] o_curBombMap_1,
    output logic [1:0]       o_bombCountA,
    output logic [1:0]       o_bombCountB,
    output logic             o_dropAckA,
    output logic             o_dropAckB,
    output logic             o_dropRejA,
    output logic             o_dropRejB
);

    function automatic logic [6:0] popCount(input logic [MAP_W-1:0] v);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < MAP_W; i++) begin
            n = n + 7'(v[i]);
        end
        return n;
    endfunction

    // count - cleared + placed, held inside 0..MAX_BOMBS.
    function automatic logic [1:0] satCount(input logic [1:0] cur,
                                            input logic [6:0] dec,
                                            input logic       inc);
        int v;
        v = int'(cur) - int'(dec) + int'(inc);
        if (v < 0)         v = 0;
        if (v > MAX_BOMBS) v = MAX_BOMBS;
        return 2'(v);
    endfunction

    logic             bombClkSync;
    logic             tick;
    logic [MAP_W-1:0] ownerMap;     // 0 = A, 1 = B; meaningful only where the cell is nonzero
    logic             pendA, pendB;
    logic             dropAPrev, dropBPrev;

    clk_edge_sync #(
        .STAGES(SYNC_STAGES)
    ) uBombClkSync (
        .clk      (clk),
        .rst      (rst),
        .asyncIn  (bombClk),
        .syncOut  (bombClkSync),
        .risePulse(tick)
    );

    // Requests resolve only while the synced bomb clock is low, so the map
    // never changes near the ticker's sampling edge and never on a tick cycle.
    logic evalEn, evalA, evalB;
    assign evalEn = ~bombClkSync;
    assign evalA  = pendA & evalEn;
    assign evalB  = pendB & evalEn;

    logic             inRangeA, inRangeB;
    logic [7:0]       idxA, idxB;
    logic [MAP_W-1:0] maskA, maskB, occupied;
    assign inRangeA = inInterior(playerAx) && inInterior(playerAy);
    assign inRangeB = inInterior(playerBx) && inInterior(playerBy);
    assign idxA     = cell_index(playerAx, playerAy);
    assign idxB     = cell_index(playerBx, playerBy);
    assign maskA    = inRangeA ? (MAP_W'(1) << idxA) : '0;
    assign maskB    = inRangeB ? (MAP_W'(1) << idxB) : '0;
    assign occupied = o_curBombMap_0 | o_curBombMap_1;

    logic okA, okB, acceptA, acceptB;
    assign okA = (game_state == 2'd0) && inRangeA && (o_bombCountA != 2'(MAX_BOMBS))
                 && ((occupied & maskA) == '0);
    assign okB = (game_state == 2'd0) && inRangeB && (o_bombCountB != 2'(MAX_BOMBS))
                 && ((occupied & maskB) == '0);
    assign acceptA = evalA && okA;
    // A wins a same-cycle race for the same cell.
    assign acceptB = evalB && okB && !(acceptA && (maskA == maskB));

    logic [MAP_W-1:0] placeMaskA, placeMaskB, placeMask;
    assign placeMaskA = acceptA ? maskA : '0;
    assign placeMaskB = acceptB ? maskB : '0;
    assign placeMask  = placeMaskA | placeMaskB;

    // Cells that were live and come back empty from the ticker.
    logic [MAP_W-1:0] clearedMap;
    logic [6:0]       clearedA, clearedB;
    assign clearedMap = occupied & ~(i_updatedBombMap_0 | i_updatedBombMap_1) & INTERIOR_MASK;
    assign clearedA   = tick ? popCount(clearedMap & ~ownerMap) : 7'd0;
    assign clearedB   = tick ? popCount(clearedMap &  ownerMap) : 7'd0;

    logic riseA, riseB;
    assign riseA = dropA & ~dropAPrev;
    assign riseB = dropB & ~dropBPrev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_curBombMap_0 <= '0;
            o_curBombMap_1 <= '0;
            ownerMap       <= '0;
            o_bombCountA   <= '0;
            o_bombCountB   <= '0;
            o_dropAckA     <= 1'b0;
            o_dropAckB     <= 1'b0;
            o_dropRejA     <= 1'b0;
            o_dropRejB     <= 1'b0;
            pendA          <= 1'b0;
            pendB          <= 1'b0;
            dropAPrev      <= 1'b0;
            dropBPrev      <= 1'b0;
        end else begin
            dropAPrev <= dropA;
            dropBPrev <= dropB;

            // A press while a request is still pending is dropped.
            pendA <= (pendA & ~evalA) | (riseA & ~pendA);
            pendB <= (pendB & ~evalB) | (riseB & ~pendB);

            o_dropAckA <= acceptA;
            o_dropAckB <= acceptB;
            o_dropRejA <= evalA & ~acceptA;
            o_dropRejB <= evalB & ~acceptB;

            o_bombCountA <= satCount(o_bombCountA, clearedA, acceptA);
            o_bombCountB <= satCount(o_bombCountB, clearedB, acceptB);

            if (tick) begin
                o_curBombMap_0 <= i_updatedBombMap_0 & INTERIOR_MASK;
                o_curBombMap_1 <= i_updatedBombMap_1 & INTERIOR_MASK;
                ownerMap       <= ownerMap & ~clearedMap;
            end else begin
                // New bombs start in fuse state 1: plane0 set, plane1 clear.
                o_curBombMap_0 <= o_curBombMap_0 | placeMask;
                o_curBombMap_1 <= o_curBombMap_1 & ~placeMask;
                ownerMap       <= (ownerMap & ~placeMaskA) | placeMaskB;
            end
        end
    end

endmodule

// File: tb/tb_bomb_placer.sv
module tb_bomb_placer;

    localparam int MAXB = 2;
    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        bombClk;
    logic [1:0]  game_state;
    logic        dropA, dropB;
    logic [3:0]  playerAx, playerAy, playerBx, playerBy;
    logic [99:0] updMap0, updMap1;
    logic [99:0] curMap0, curMap1;
    logic [1:0]  cntA, cntB;
    logic        ackA, ackB, rejA, rejB;

    always #5 clk = ~clk;

    bomb_placer #(
        .MAX_BOMBS  (MAXB),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .bombClk           (bombClk),
        .game_state        (game_state),
        .dropA             (dropA),
        .dropB             (dropB),
        .playerAx          (playerAx),
        .playerAy          (playerAy),
        .playerBx          (playerBx),
        .playerBy          (playerBy),
        .i_updatedBombMap_0(updMap0),
        .i_updatedBombMap_1(updMap1),
        .o_curBombMap_0    (curMap0),
        .o_curBombMap_1    (curMap1),
        .o_bombCountA      (cntA),
        .o_bombCountB      (cntB),
        .o_dropAckA        (ackA),
        .o_dropAckB        (ackB),
        .o_dropRejA        (rejA),
        .o_dropRejB        (rejB)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: plain per-cell state, owner and per-player counts.
    int cellSt[100];
    int own[100];
    int cnt[2];
    int gs;

    typedef struct {
        int player;
        bit ack;
        int count;
    } exp_t;
    exp_t expQ[$];

    function automatic int nextSt(input int s);
        if (s == 0 || s == 3) return 0;
        return s + 1;
    endfunction

    task automatic modelClear();
        for (int i = 0; i < 100; i++) begin
            cellSt[i] = 0;
            own[i] = 0;
        end
        cnt[0] = 0;
        cnt[1] = 0;
    endtask

    task automatic modelPress(input int p, input int x, input int y);
        exp_t e;
        bit acc;
        acc = 1'b1;
        if (gs != 0 || x < 1 || x > 8 || y < 1 || y > 8) acc = 1'b0;
        else if (cnt[p] == MAXB) acc = 1'b0;
        else if (cellSt[10*x + y] != 0) acc = 1'b0;
        if (acc) begin
            cellSt[10*x + y] = 1;
            own[10*x + y] = p;
            cnt[p]++;
        end
        e.player = p;
        e.ack = acc;
        e.count = cnt[p];
        expQ.push_back(e);
    endtask

    task automatic cmp(input string name, input logic [99:0] act, input logic [99:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic checkState(input string name);
        logic [99:0] e0, e1;
        e0 = '0;
        e1 = '0;
        for (int i = 0; i < 100; i++) begin
            e0[i] = cellSt[i][0];
            e1[i] = cellSt[i][1];
        end
        cmp({name, ".plane0"}, curMap0, e0);
        cmp({name, ".plane1"}, curMap1, e1);
        cmp({name, ".countA"}, 100'(cntA), 100'(cnt[0]));
        cmp({name, ".countB"}, 100'(cntB), 100'(cnt[1]));
    endtask

    task automatic drainCheck(input string name);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL %s.responseTimeout pending=%0d required=0", name, expQ.size());
            expQ.delete();
        end
    endtask

    // Scoreboard monitor: pops one expectation per observed response pulse.
    task automatic checkPulse(input int p, input logic ack, input logic rej, input logic [1:0] c);
        exp_t e;
        checks++;
        if (expQ.size() == 0) begin
            errors++;
            $display("FAIL unexpectedPulse player=%0d ack=%0b rej=%0b required=no pulse", p, ack, rej);
        end else begin
            e = expQ.pop_front();
            if (e.player != p || e.ack != ack || ack == rej || int'(c) != e.count) begin
                errors++;
                $display("FAIL dropResponse actual player=%0d ack=%0b rej=%0b count=%0d required player=%0d ack=%0b count=%0d",
                         p, ack, rej, c, e.player, e.ack, e.count);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (ackA | rejA) checkPulse(0, ackA, rejA, cntA);
            if (ackB | rejB) checkPulse(1, ackB, rejB, cntB);
        end
    end

    // Entered and left at posedge+1 with bombClk low and settled.
    task automatic press(input bit useA, input bit useB,
                         input int ax, input int ay, input int bx, input int by,
                         input string name);
        playerAx = 4'(ax);
        playerAy = 4'(ay);
        playerBx = 4'(bx);
        playerBy = 4'(by);
        game_state = 2'(gs);
        if (useA) modelPress(0, ax, ay);
        if (useB) modelPress(1, bx, by);
        dropA = useA;
        dropB = useB;
        repeat (3) @(posedge clk);
        #1;
        dropA = 1'b0;
        dropB = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkState(name);
        drainCheck(name);
        @(posedge clk);
        #1;
    endtask

    // Plays the ticker: presents the aged map, raises bombClk and checks the
    // merge lands exactly SYNC+1 clk edges after the raw edge.
    task automatic doTick(input string name);
        logic [99:0] u0, u1;
        int ns;
        u0 = '0;
        u1 = '0;
        for (int i = 0; i < 100; i++) begin
            ns = nextSt(cellSt[i]);
            u0[i] = ns[0];
            u1[i] = ns[1];
        end
        updMap0 = u0;
        updMap1 = u1;
        bombClk = 1'b1;
        repeat (SYNC) @(posedge clk);
        @(negedge clk);
        checkState({name, ".beforeMerge"});
        @(posedge clk);
        for (int i = 0; i < 100; i++) begin
            ns = nextSt(cellSt[i]);
            if (cellSt[i] != 0 && ns == 0) cnt[own[i]]--;
            cellSt[i] = ns;
        end
        @(negedge clk);
        checkState({name, ".merge"});
        repeat (3) @(posedge clk);
        #1;
        bombClk = 1'b0;
        repeat (SYNC + 2) @(posedge clk);
        #1;
    endtask

    function automatic int rc();
        if ($urandom_range(0, 4) == 0) return int'($urandom_range(0, 9));
        return int'($urandom_range(1, 4));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bombClk = 1'b0;
        game_state = 2'd0;
        dropA = 1'b0;
        dropB = 1'b0;
        playerAx = '0;
        playerAy = '0;
        playerBx = '0;
        playerBy = '0;
        updMap0 = '0;
        updMap1 = '0;
        gs = 0;
        modelClear();

        repeat (3) @(posedge clk);
        #1;
        checkState("resetState");
        cmp("resetPulses", 100'({ackA, ackB, rejA, rejB}), 100'(0));
        rst = 1'b0;
        repeat (SYNC + 2) @(posedge clk);
        #1;

        // Single placement and full lifecycle
        press(1, 0, 3, 4, 0, 0, "placeA34");
        doTick("life1to2");
        doTick("life2to3");
        doTick("life3to0");
        doTick("lifeIdle");

        // Per-player limit
        press(1, 0, 1, 1, 0, 0, "limit11");
        press(1, 0, 2, 2, 0, 0, "limit22");
        press(1, 0, 5, 5, 0, 0, "limit55");

        // Reset mid-run with a drop pending
        playerAx = 4'd5;
        playerAy = 4'd6;
        dropA = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        modelClear();
        checkState("asyncReset");
        dropA = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        checkState("postReset");
        drainCheck("postReset");

        // Contention on one cell, then drain to see ownership
        press(1, 1, 6, 6, 6, 6, "contention");
        doTick("cont1");
        doTick("cont2");
        doTick("cont3");

        // B refusals: occupied, out of range, game over
        press(1, 0, 4, 4, 0, 0, "occupySetup");
        press(0, 1, 0, 0, 4, 4, "rejOccupied");
        press(0, 1, 0, 0, 9, 3, "rejRange");
        gs = 2;
        press(0, 1, 0, 0, 7, 7, "rejGameOver");
        doTick("gameOverTick");
        gs = 0;

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r <= 3)      press(1, 0, rc(), rc(), 0, 0, "randA");
            else if (r <= 5) press(0, 1, 0, 0, rc(), rc(), "randB");
            else if (r == 6) press(1, 1, rc(), rc(), rc(), rc(), "randAB");
            else if (r <= 8) doTick("randTick");
            else             gs = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        end

        repeat (4) @(posedge clk);
        drainCheck("final");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
